// File: rtl/multi_button_conditioner.sv
// multi_button_conditioner: N-channel two-flop sync, stable-count debounce, edge pulses and long-press pulse (long press built only when MULTI_BUTTON_CONDITIONER_LONG_PRESS_EN is defined)
module multi_button_conditioner #(
    parameter int N           = 4,
    parameter int DB_CYCLES   = 20000,
    parameter int LONG_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] btn_in,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] p_edge,
    output logic [N-1:0] n_edge,
    output logic [N-1:0] long_press
);
    localparam int DW = $clog2(DB_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_ch
            logic s1, s2, lvl, pe, ne, acc;
            logic [DW-1:0] db_cnt;
            assign acc = (s2 != lvl) && (db_cnt == DW'(DB_CYCLES - 1));
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    {s1, s2, lvl, pe, ne} <= '0;
                    db_cnt <= '0;
                end else begin
                    s1 <= btn_in[i];
                    s2 <= s1;
                    db_cnt <= (s2 == lvl || acc) ? '0 : db_cnt + 1'b1;
                    lvl <= acc ? s2 : lvl;
                    pe <= acc & s2;
                    ne <= acc & ~s2;
                end
            end
            assign btn_level[i] = lvl;
            assign p_edge[i]    = pe;
            assign n_edge[i]    = ne;
`ifdef MULTI_BUTTON_CONDITIONER_LONG_PRESS_EN
            logic [HW-1:0] hold_cnt;
            logic lp;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    hold_cnt <= '0;
                    lp <= 1'b0;
                end else begin
                    hold_cnt <= !lvl ? '0 : (hold_cnt == HW'(LONG_CYCLES)) ? hold_cnt : hold_cnt + 1'b1;
                    lp <= lvl && (hold_cnt == HW'(LONG_CYCLES - 1));
                end
            end
            assign long_press[i] = lp;
`else
            assign long_press[i] = 1'b0;
`endif
        end
    endgenerate
endmodule

// File: tb/tb_multi_button_conditioner.sv
// tb_multi_button_conditioner: randomized and directed checks of multi_button_conditioner against a cycle-level reference model
module tb_multi_button_conditioner;
    localparam int N    = 4;
    localparam int DB   = 8;
    localparam int LONG = 32;
`ifdef MULTI_BUTTON_CONDITIONER_LONG_PRESS_EN
    localparam bit LP = 1'b1;
`else
    localparam bit LP = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [N-1:0] btn_in = '0;
    logic [N-1:0] btn_level, p_edge, n_edge, long_press;
    int checks = 0;
    int errors = 0;

    multi_button_conditioner #(.N(N), .DB_CYCLES(DB), .LONG_CYCLES(LONG)) dut (
        .clk(clk), .reset_n(reset_n), .btn_in(btn_in),
        .btn_level(btn_level), .p_edge(p_edge), .n_edge(n_edge), .long_press(long_press)
    );

    always #5 clk = ~clk;

    // Reference: a level is accepted once the synchronised input has disagreed
    // with it for DB consecutive clocks; long press fires LONG clocks after the
    // accepting clock of a press, provided the level is still high.
    logic [N-1:0] m_s1, m_s2, m_lvl, m_pe, m_ne, m_lp;
    int m_run [N];
    int m_age [N];
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_s1 <= '0; m_s2 <= '0; m_lvl <= '0; m_pe <= '0; m_ne <= '0; m_lp <= '0;
            for (int i = 0; i < N; i++) begin
                m_run[i] <= 0;
                m_age[i] <= 0;
            end
        end else begin
            m_s1 <= btn_in;
            m_s2 <= m_s1;
            for (int i = 0; i < N; i++) begin
                m_run[i] <= (m_s2[i] == m_lvl[i] || m_run[i] + 1 == DB) ? 0 : m_run[i] + 1;
                m_lvl[i] <= (m_s2[i] != m_lvl[i] && m_run[i] + 1 == DB) ? m_s2[i] : m_lvl[i];
                m_pe[i] <= m_s2[i] && !m_lvl[i] && m_run[i] + 1 == DB;
                m_ne[i] <= !m_s2[i] && m_lvl[i] && m_run[i] + 1 == DB;
                m_age[i] <= (m_s2[i] && !m_lvl[i] && m_run[i] + 1 == DB) ? 0 : (m_age[i] < 1000000 ? m_age[i] + 1 : m_age[i]);
                m_lp[i] <= LP && m_lvl[i] && m_age[i] + 1 == LONG;
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        btn_in = '0;
        cyc(3);
        checks++;
        if ({btn_level, p_edge, n_edge, long_press} !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h expected 0", {btn_level, p_edge, n_edge, long_press});
        end
        reset_n = 1'b1;
        cyc(4);
        checks++;
        if ({btn_level, p_edge, n_edge, long_press} !== '0) begin
            errors++;
            $display("FAIL reset_idle: got %h expected 0", {btn_level, p_edge, n_edge, long_press});
        end
    endtask

    task automatic test_clean_press;
        btn_in[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            checks++;
            if ({btn_level[0], p_edge[0]} !== {k >= 10, k == 10}) begin
                errors++;
                $display("FAIL clean_press k=%0d: level/p_edge %b expected %b", k, {btn_level[0], p_edge[0]}, {k >= 10, k == 10});
            end
        end
        btn_in[0] = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            cyc();
            checks++;
            if ({btn_level[0], n_edge[0]} !== {k < 10, k == 10}) begin
                errors++;
                $display("FAIL clean_release k=%0d: level/n_edge %b expected %b", k, {btn_level[0], n_edge[0]}, {k < 10, k == 10});
            end
        end
    endtask

    task automatic test_bounce;
        for (int t = 0; t < 40; t++) begin
            btn_in[1] = ((t / 3) % 2 == 0);
            cyc();
            checks++;
            if ({btn_level[1], p_edge[1], n_edge[1]} !== 3'b000) begin
                errors++;
                $display("FAIL bounce_quiet t=%0d: got %b expected 000", t, {btn_level[1], p_edge[1], n_edge[1]});
            end
        end
        btn_in[1] = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            cyc();
            checks++;
            if ({btn_level[1], p_edge[1]} !== {k >= 10, k == 10}) begin
                errors++;
                $display("FAIL bounce_settle k=%0d: level/p_edge %b expected %b", k, {btn_level[1], p_edge[1]}, {k >= 10, k == 10});
            end
        end
        btn_in[1] = 1'b0;
        cyc(7);
        btn_in[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            checks++;
            if ({btn_level[1], n_edge[1]} !== 2'b10) begin
                errors++;
                $display("FAIL glitch k=%0d: level/n_edge %b expected 10", k, {btn_level[1], n_edge[1]});
            end
        end
        btn_in[1] = 1'b0;
        cyc(14);
    endtask

    task automatic test_long_press;
        int seen;
        btn_in[2] = 1'b1;
        seen = 0;
        for (int k = 1; k <= 12 && seen == 0; k++) begin
            cyc();
            if (p_edge[2]) seen = k;
        end
        checks++;
        if (seen != 10) begin
            errors++;
            $display("FAIL long_pedge_latency: got %0d expected 10", seen);
        end
        for (int k = 1; k <= 60; k++) begin
            cyc();
            checks++;
            if (long_press !== ((LP && k == 32) ? 4'b0100 : 4'b0000)) begin
                errors++;
                $display("FAIL long_fire k=%0d: got %b expected %b", k, long_press, (LP && k == 32) ? 4'b0100 : 4'b0000);
            end
        end
        btn_in[2] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            checks++;
            if ({n_edge[2], long_press} !== {k == 10, 4'b0000}) begin
                errors++;
                $display("FAIL long_release k=%0d: got %b expected %b", k, {n_edge[2], long_press}, {k == 10, 4'b0000});
            end
        end
        cyc(3);
        btn_in[2] = 1'b1;
        cyc(10);
        checks++;
        if ({btn_level[2], p_edge[2]} !== 2'b11) begin
            errors++;
            $display("FAIL short_press_accept: got %b expected 11", {btn_level[2], p_edge[2]});
        end
        cyc(20);
        btn_in[2] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            checks++;
            if ({n_edge[2], btn_level[2], long_press} !== {k == 10, k < 10, 4'b0000}) begin
                errors++;
                $display("FAIL short_release k=%0d: got %b expected %b", k, {n_edge[2], btn_level[2], long_press}, {k == 10, k < 10, 4'b0000});
            end
        end
    endtask

    task automatic test_simultaneous;
        btn_in = 4'b1111;
        for (int k = 1; k <= 11; k++) begin
            cyc();
            checks++;
            if (p_edge !== (k == 10 ? 4'b1111 : 4'b0000)) begin
                errors++;
                $display("FAIL simul_press k=%0d: got %b expected %b", k, p_edge, k == 10 ? 4'b1111 : 4'b0000);
            end
        end
        cyc(4);
        btn_in = 4'b1010;
        for (int k = 1; k <= 11; k++) begin
            cyc();
            checks++;
            if (n_edge !== (k == 10 ? 4'b0101 : 4'b0000)) begin
                errors++;
                $display("FAIL simul_release k=%0d: got %b expected %b", k, n_edge, k == 10 ? 4'b0101 : 4'b0000);
            end
        end
        btn_in = 4'b0000;
        cyc(14);
    endtask

    task automatic test_reset_mid;
        btn_in[1] = 1'b1;
        cyc(10);
        cyc(13);
        btn_in[0] = 1'b1;
        cyc(7);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({btn_level, p_edge, n_edge, long_press} !== '0) begin
            errors++;
            $display("FAIL reset_async: got %h expected 0", {btn_level, p_edge, n_edge, long_press});
        end
        cyc(2);
        reset_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            checks++;
            if ({p_edge, n_edge, long_press} !== {(k == 10) ? 4'b0011 : 4'b0000, 8'h00}) begin
                errors++;
                $display("FAIL reset_rearm k=%0d: got %b expected %b", k, {p_edge, n_edge, long_press}, {(k == 10) ? 4'b0011 : 4'b0000, 8'h00});
            end
        end
        btn_in = '0;
        cyc(14);
    endtask

    task automatic test_random;
        int rate;
        rate = 4;
        for (int c = 0; c < 4000; c++) begin
            if (c % 150 == 0) rate = (c / 150) % 3 == 0 ? 3 : ((c / 150) % 3 == 1 ? 12 : 80);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, rate - 1) == 0) btn_in[i] = ~btn_in[i];
            cyc();
            checks++;
            if ({btn_level, p_edge, n_edge, long_press} !== {m_lvl, m_pe, m_ne, m_lp}) begin
                errors++;
                $display("FAIL random c=%0d: lvl/pe/ne/lp %b expected %b", c, {btn_level, p_edge, n_edge, long_press}, {m_lvl, m_pe, m_ne, m_lp});
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
